can_bit_stuffer: RTL and testbench

CAN_BIT_STUFFER -- requirements
Module: can_bit_stuffer

---
 rtl/can_pkg.sv | 23 ++
 rtl/stuff_run_counter.sv | 62 ++++++
 rtl/can_bit_stuffer.sv | 153 +++++++++++++++
 tb/tb_can_bit_stuffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared constants and types for the CAN bit-stuffing datapath.
//   STUFF_LEN : number of identical consecutive bits after which a
//               complementary stuff bit is inserted.
//   RECESSIVE : idle/recessive bus level.
//   stuff_state_t : stuffer FSM states.
//     IDLE  - outside the stuff area, bits passed straight through
//     STUFF - inside the stuff area, runs are tracked
//     PEND  - stuff area has closed but a stuff bit is still owed
// ---------------------------------------------------------------------------
package can_pkg;

   localparam int   STUFF_LEN = 5;
   localparam logic RECESSIVE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STUFF = 2'd1,
      PEND  = 2'd2
   } stuff_state_t;

endpackage

// File: rtl/stuff_run_counter.sv
// ---------------------------------------------------------------------------
// stuff_run_counter
// Tracks the length of the current run of identical bus bits and the value
// of the last bit of that run.  Shared by the transmit stuffer and the
// receive stuff-error checker.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous active-low reset (count 0, last bit recessive)
//   clear      : drop the run (count to 0, last bit kept)
//   load       : start a new run with bit_in (count 1)
//   step       : append bit_in to the run (extend or restart at 1)
//   bit_in     : bit being loaded/appended
//   run_cnt    : current run length, 0..STUFF_LEN
//   last_bit   : value of the most recent bit in the run
//   at_limit   : run_cnt has reached STUFF_LEN
//   step_hits  : appending bit_in now would bring the run to STUFF_LEN
// Priority when several controls are asserted: clear, load, step.
// ---------------------------------------------------------------------------
module stuff_run_counter
   import can_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic       step,
   input  logic       bit_in,
   output logic [2:0] run_cnt,
   output logic       last_bit,
   output logic       at_limit,
   output logic       step_hits
);

   localparam logic [2:0] LIMIT      = 3'(STUFF_LEN);
   localparam logic [2:0] LIMIT_LESS = 3'(STUFF_LEN - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt  <= 3'd0;
         last_bit <= RECESSIVE;
      end else if (clear) begin
         run_cnt  <= 3'd0;
      end else if (load) begin
         run_cnt  <= 3'd1;
         last_bit <= bit_in;
      end else if (step) begin
         last_bit <= bit_in;
         // Saturate so the count can never leave 0..STUFF_LEN, even if a
         // caller keeps stepping an already complete run.
         if (bit_in == last_bit && run_cnt < LIMIT) begin
            run_cnt <= run_cnt + 3'd1;
         end else begin
            run_cnt <= 3'd1;
         end
      end
   end

   assign at_limit  = (run_cnt == LIMIT);
   assign step_hits = (run_cnt == LIMIT_LESS) && (bit_in == last_bit);

endmodule

// File: rtl/can_bit_stuffer.sv
// ---------------------------------------------------------------------------
// can_bit_stuffer
// CAN transmit bit stuffer.  On each transmit point it either forwards the
// next frame bit from the frame generator or, after STUFF_LEN identical bits
// inside the stuff area, drives a complementary stuff bit instead and holds
// the frame bit for the following bit time.
//
// Ports
//   clk       : system clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   TP        : transmit-point strobe, one clk wide per bit time
//   TX_IN     : next unstuffed frame bit, held until BIT_ACK
//   F_STF     : stuff-area flag, active-low (0 = stuffing enabled)
//   TX        : registered bus bit, 1 = recessive
//   BIT_ACK   : one-clk pulse, TX_IN consumed this bit time
//   STUFF_INS : one-clk pulse, a stuff bit is on TX this bit time
//   RUN_CNT   : current identical-bit run length, 0..5
//
// Handshake: TX_IN/BIT_ACK is a hold-until-acknowledged interface.  The
// frame generator presents a bit and keeps it stable; BIT_ACK=1 for one
// clk (the cycle after the TP edge) means the bit went out on TX and the
// generator may present the next one.  STUFF_INS and BIT_ACK are mutually
// exclusive: a stuff-bit time never consumes a frame bit.
//
// The FSM state is visible as the internal signal state_q.
// ---------------------------------------------------------------------------
module can_bit_stuffer
   import can_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       TP,
   input  logic       TX_IN,
   input  logic       F_STF,
   output logic       TX,
   output logic       BIT_ACK,
   output logic       STUFF_INS,
   output logic [2:0] RUN_CNT
);

   stuff_state_t state_q;
   stuff_state_t state_d;

   logic tx_d;
   logic ack_d;
   logic stf_d;

   logic cnt_clear;
   logic cnt_load;
   logic cnt_step;
   logic cnt_bit;
   logic last_bit;
   logic at_limit;
   logic step_hits;

   stuff_run_counter u_run (
      .clk       (clk),
      .reset     (reset),
      .clear     (cnt_clear),
      .load      (cnt_load),
      .step      (cnt_step),
      .bit_in    (cnt_bit),
      .run_cnt   (RUN_CNT),
      .last_bit  (last_bit),
      .at_limit  (at_limit),
      .step_hits (step_hits)
   );

   always_comb begin
      state_d   = state_q;
      tx_d      = TX;
      ack_d     = 1'b0;
      stf_d     = 1'b0;
      cnt_clear = 1'b0;
      cnt_load  = 1'b0;
      cnt_step  = 1'b0;
      cnt_bit   = TX_IN;

      if (TP) begin
         unique case (state_q)
            IDLE: begin
               tx_d  = TX_IN;
               ack_d = 1'b1;
               if (!F_STF) begin
                  // This bit (SOF) is the first bit of the first run.
                  cnt_load = 1'b1;
                  state_d  = STUFF;
               end else begin
                  cnt_clear = 1'b1;
               end
            end

            STUFF: begin
               if (at_limit) begin
                  // A stuff bit is owed: it is sent now whatever F_STF says,
                  // so a run closed by the last CRC bit is still stuffed.
                  tx_d  = ~last_bit;
                  stf_d = 1'b1;
                  if (F_STF) begin
                     cnt_clear = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     // Stuff bit opens the next run.
                     cnt_load = 1'b1;
                     cnt_bit  = ~last_bit;
                  end
               end else begin
                  tx_d  = TX_IN;
                  ack_d = 1'b1;
                  if (!F_STF) begin
                     cnt_step = 1'b1;
                  end else if (step_hits) begin
                     // Area closes on the bit that completes a run: the
                     // stuff bit is still owed at the next TP.
                     cnt_step = 1'b1;
                     state_d  = PEND;
                  end else begin
                     cnt_clear = 1'b1;
                     state_d   = IDLE;
                  end
               end
            end

            PEND: begin
               tx_d      = ~last_bit;
               stf_d     = 1'b1;
               cnt_clear = 1'b1;
               state_d   = IDLE;
            end

            default: begin
               state_d   = IDLE;
               cnt_clear = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         TX        <= RECESSIVE;
         BIT_ACK   <= 1'b0;
         STUFF_INS <= 1'b0;
      end else begin
         state_q   <= state_d;
         TX        <= tx_d;
         BIT_ACK   <= ack_d;
         STUFF_INS <= stf_d;
      end
   end

endmodule

// File: tb/tb_can_bit_stuffer.sv
// ---------------------------------------------------------------------------
// tb_can_bit_stuffer
// Directed and randomized stimulus for can_bit_stuffer.  Expected bus bits
// come from a reference model that keeps the history of transmitted bits in
// the current stuff area and looks at how many trailing bits are identical.
// ---------------------------------------------------------------------------
module tb_can_bit_stuffer;

   logic       clk;
   logic       reset;
   logic       TP;
   logic       TX_IN;
   logic       F_STF;
   logic       TX;
   logic       BIT_ACK;
   logic       STUFF_INS;
   logic [2:0] RUN_CNT;

   int checks = 0;
   int errors = 0;

   can_bit_stuffer dut (
      .clk       (clk),
      .reset     (reset),
      .TP        (TP),
      .TX_IN     (TX_IN),
      .F_STF     (F_STF),
      .TX        (TX),
      .BIT_ACK   (BIT_ACK),
      .STUFF_INS (STUFF_INS),
      .RUN_CNT   (RUN_CNT)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   bit m_hist[$];    // bits sent since the current stuff area opened
   bit m_area;       // inside the stuff area
   bit m_pend;       // stuff bit owed after the area closed
   bit m_tx;
   bit m_ack;
   bit m_stf;
   int m_cnt;

   function automatic int trailing();
      int n;
      n = 0;
      if (m_hist.size() == 0) return 0;
      for (int i = m_hist.size() - 1; i >= 0; i--) begin
         if (m_hist[i] == m_hist[m_hist.size() - 1]) n++;
         else break;
      end
      return n;
   endfunction

   task automatic model_reset();
      m_hist.delete();
      m_area = 1'b0;
      m_pend = 1'b0;
      m_tx   = 1'b1;
      m_ack  = 1'b0;
      m_stf  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_push(input bit b);
      m_hist.push_back(b);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
   endtask

   task automatic model_tp(input bit d, input bit f);
      m_ack = 1'b0;
      m_stf = 1'b0;
      if (m_pend) begin
         m_tx = !m_hist[m_hist.size() - 1];
         m_stf = 1'b1;
         m_hist.delete();
         m_area = 1'b0;
         m_pend = 1'b0;
      end else if (m_area && trailing() == 5) begin
         m_tx = !m_hist[m_hist.size() - 1];
         m_stf = 1'b1;
         if (f) begin
            m_hist.delete();
            m_area = 1'b0;
         end else begin
            model_push(m_tx);
         end
      end else if (m_area) begin
         m_tx = d;
         m_ack = 1'b1;
         model_push(d);
         if (f) begin
            if (trailing() == 5) m_pend = 1'b1;
            else begin
               m_hist.delete();
               m_area = 1'b0;
            end
         end
      end else begin
         m_tx = d;
         m_ack = 1'b1;
         if (!f) begin
            m_area = 1'b1;
            model_push(d);
         end
      end
      m_cnt = trailing();
   endtask

   // ---------------- driver / checker ----------------
   bit src_q[$];
   int ack_seen;
   int stuff_seen;
   int max_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      ack_seen   = 0;
      stuff_seen = 0;
      max_cnt    = 0;
   endtask

   task automatic do_tp(input bit f);
      bit d;
      d = (src_q.size() > 0) ? src_q[0] : 1'b1;
      model_tp(d, f);
      @(negedge clk);
      TP    = 1'b1;
      TX_IN = d;
      F_STF = f;
      @(negedge clk);
      TP = 1'b0;
      check("tx", 32'(TX), 32'(m_tx));
      check("bit_ack", 32'(BIT_ACK), 32'(m_ack));
      check("stuff_ins", 32'(STUFF_INS), 32'(m_stf));
      check("run_cnt", 32'(RUN_CNT), 32'(m_cnt));
      if (BIT_ACK) ack_seen++;
      if (STUFF_INS) stuff_seen++;
      if (int'(RUN_CNT) > max_cnt) max_cnt = int'(RUN_CNT);
      if (m_ack && src_q.size() > 0) void'(src_q.pop_front());
      // Quiet cycle: everything held, pulses gone.
      @(negedge clk);
      check("hold_tx", 32'(TX), 32'(m_tx));
      check("hold_ack", 32'(BIT_ACK), 32'd0);
      check("hold_stuff", 32'(STUFF_INS), 32'd0);
      check("hold_cnt", 32'(RUN_CNT), 32'(m_cnt));
   endtask

   task automatic drain();
      src_q.delete();
      for (int i = 0; i < 3; i++) do_tp(1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit b;
      int len;

      reset = 1'b1;
      TP    = 1'b0;
      TX_IN = 1'b0;
      F_STF = 1'b1;
      model_reset();
      #2 reset = 1'b0;
      #1;
      check("reset_tx", 32'(TX), 32'd1);
      check("reset_ack", 32'(BIT_ACK), 32'd0);
      check("reset_stuff", 32'(STUFF_INS), 32'd0);
      check("reset_cnt", 32'(RUN_CNT), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Six zeros in the stuff area: stuff 1 after the fifth.
      clear_stats();
      src_q = '{0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 7; i++) do_tp(1'b0);
      check("six_zero_acks", 32'(ack_seen), 32'd6);
      check("six_zero_stuffs", 32'(stuff_seen), 32'd1);
      drain();

      // Alternating bits never stuff.
      clear_stats();
      for (int i = 0; i < 20; i++) src_q.push_back(bit'(~i[0]));
      for (int i = 0; i < 20; i++) do_tp(1'b0);
      check("alt_stuffs", 32'(stuff_seen), 32'd0);
      check("alt_max_cnt", 32'(max_cnt), 32'd1);
      drain();

      // Run of five ones completed as the stuff area closes.
      clear_stats();
      src_q = '{0, 1, 1, 1, 1, 1, 0, 1};
      for (int i = 0; i < 5; i++) do_tp(1'b0);
      do_tp(1'b1);
      do_tp(1'b1);
      check("pend_stuff_tx", 32'(TX), 32'd0);
      check("pend_stuff_ins", 32'(STUFF_INS), 32'd0);
      do_tp(1'b1);
      check("pend_stuffs", 32'(stuff_seen), 32'd1);
      drain();

      // Outside the stuff area nothing is stuffed.
      clear_stats();
      for (int i = 0; i < 11; i++) src_q.push_back(1'b1);
      for (int i = 0; i < 11; i++) do_tp(1'b1);
      check("idle_acks", 32'(ack_seen), 32'd11);
      check("idle_stuffs", 32'(stuff_seen), 32'd0);
      drain();

      // Stuff bit counts as the first bit of the next run.
      clear_stats();
      src_q = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 11; i++) do_tp(1'b0);
      check("chain_stuffs", 32'(stuff_seen), 32'd2);
      drain();

      // Asynchronous reset with RUN_CNT at 4.
      src_q = '{1, 1, 1, 1};
      for (int i = 0; i < 4; i++) do_tp(1'b0);
      check("pre_reset_cnt", 32'(RUN_CNT), 32'd4);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_tx", 32'(TX), 32'd1);
      check("async_cnt", 32'(RUN_CNT), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_stats();
      src_q = '{1, 1, 1, 1, 1, 1};
      for (int i = 0; i < 5; i++) do_tp(1'b0);
      check("post_reset_no_stuff", 32'(stuff_seen), 32'd0);
      do_tp(1'b0);
      check("post_reset_stuff", 32'(stuff_seen), 32'd1);
      drain();

      // Reset while a stuff bit is owed discards it.
      src_q = '{0, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) do_tp(1'b0);
      do_tp(1'b1);
      @(posedge clk);
      #2 reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_stats();
      src_q = '{0};
      do_tp(1'b1);
      check("pend_reset_no_stuff", 32'(stuff_seen), 32'd0);
      drain();

      // Randomized frames with run-biased data.
      for (int fr = 0; fr < 8; fr++) begin
         src_q.delete();
         len = int'($urandom_range(15, 45));
         b = 1'($urandom);
         for (int i = 0; i < len + 12; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            src_q.push_back(b);
         end
         for (int i = 0; i < len; i++) do_tp(1'b0);
         for (int i = 0; i < 4; i++) do_tp(1'b1);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 3; i++) do_tp(1'($urandom));
         end
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
